// File: rtl/cpu_uop_pkg.sv
// Shared micro-op definitions for decode_unit, uop_issue_queue and execute.
// Provides the 20-bit uop layout, field positions and a FLAGS helper.
package cpu_uop_pkg;

  localparam int unsigned UOP_W          = 20;
  localparam int unsigned UOP_ALU_LSB    = 16;
  localparam int unsigned UOP_MASK_BIT   = 15;
  localparam int unsigned UOP_LD_BIT     = 14;
  localparam int unsigned UOP_WR_BIT     = 13;
  localparam int unsigned UOP_FLAGS_BIT  = 12;
  localparam int unsigned UOP_DEST_LSB   = 8;
  localparam int unsigned UOP_ALUMUX_LSB = 6;
  localparam int unsigned UOP_B_LSB      = 3;
  localparam int unsigned UOP_A_LSB      = 0;

  // Field order matches the bit map, MSB first.
  typedef struct packed {
    logic [3:0] alu;
    logic       mask;
    logic       ld;
    logic       wr;
    logic       flags;
    logic [3:0] dest;
    logic [1:0] alu_mux;
    logic [2:0] b;
    logic [2:0] a;
  } uop_t;

  function automatic logic uop_sets_flags(input uop_t u);
    return u.flags;
  endfunction

endpackage

// File: rtl/uop_issue_queue_if.sv
// Decoder feed and execute issue handshakes of the uop issue queue.
//   master : queue side (drives feed_req, issue_valid, issue_uop)
//   slave  : decoder/execute side
interface uop_issue_queue_if;
  import cpu_uop_pkg::*;

  logic       feed_req;
  logic       feed_ack;
  uop_t       uop_0;
  uop_t       uop_1;
  uop_t       uop_2;
  logic [1:0] uop_count;
  logic       issue_valid;
  logic       issue_ready;
  uop_t       issue_uop;

  modport master (
    output feed_req, issue_valid, issue_uop,
    input  feed_ack, uop_0, uop_1, uop_2, uop_count, issue_ready
  );

  modport slave (
    input  feed_req, issue_valid, issue_uop,
    output feed_ack, uop_0, uop_1, uop_2, uop_count, issue_ready
  );
endinterface

// File: rtl/uop_fifo_mem.sv
// DEPTH x uop storage: up to 3 writes at consecutive (wrapping) addresses
// per cycle, one asynchronous read port.
//   clk, rst   : clock, synchronous active-high reset (clears all entries)
//   wr_en      : write the first wr_count uops of wr_uop starting at wr_ptr
//   rd_ptr     : read address, rd_uop is mem[rd_ptr]
module uop_fifo_mem
  import cpu_uop_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_ptr,
  input  logic [1:0]       wr_count,
  input  uop_t             wr_uop [3],
  input  logic [PTR_W-1:0] rd_ptr,
  output uop_t             rd_uop
);

  uop_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < 3; i++) begin
        if (2'(i) < wr_count) mem[wr_ptr + PTR_W'(i)] <= wr_uop[i];
      end
    end
  end

  assign rd_uop = mem[rd_ptr];

endmodule

// File: rtl/uop_issue_queue.sv
// Issue queue between decode_unit and execute: accepts 0-3 uop bundles,
// issues one uop per cycle and tracks queued/in-flight FLAGS writers.
//   clk, a_rst  : clock, synchronous active-high reset
//   bus         : feed handshake (feed_req/feed_ack/uop_0..2/uop_count)
//                 and issue handshake (issue_valid/issue_ready/issue_uop)
//   flag_commit : one in-flight FLAGS uop has written SF
//   flush       : discard queued uops; in-flight FLAGS uops still commit
//   sf_written  : nothing queued or in flight will write SF
//   occupancy   : current entry count
module uop_issue_queue
  import cpu_uop_pkg::*;
#(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic                   clk,
  input  logic                   a_rst,
  uop_issue_queue_if.master      bus,
  input  logic                   flag_commit,
  input  logic                   flush,
  output logic                   sf_written,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam int unsigned IF_W  = 3;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [OCC_W-1:0] queued_flags;
  logic [IF_W-1:0]  inflight_flags;

  uop_t       wr_uop [3];
  uop_t       head_uop;
  logic       head_flags;
  logic       push;
  logic       pop;
  logic       pop_flags;
  logic       commit_ok;
  logic [1:0] push_n;
  logic [1:0] push_flags;

  assign wr_uop[0] = bus.uop_0;
  assign wr_uop[1] = bus.uop_1;
  assign wr_uop[2] = bus.uop_2;

  uop_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk      (clk),
    .rst      (a_rst),
    .wr_en    (push),
    .wr_ptr   (tail),
    .wr_count (bus.uop_count),
    .wr_uop   (wr_uop),
    .rd_ptr   (head),
    .rd_uop   (head_uop)
  );

  // Handshake outputs are derived from registered state plus flush only.
  always_comb begin
    head_flags      = uop_sets_flags(head_uop);
    bus.issue_uop   = head_uop;
    // Room for a full 3-uop bundle is required before asking for one.
    bus.feed_req    = !flush && (occupancy <= OCC_W'(DEPTH - 3));
    bus.issue_valid = (occupancy != '0) && !flush &&
                      !(head_flags && (inflight_flags == IF_W'(MAX_INFLIGHT)));
    push            = bus.feed_req && bus.feed_ack;
    push_n          = push ? bus.uop_count : 2'd0;
    pop             = bus.issue_valid && bus.issue_ready;
    pop_flags       = pop && head_flags;
    commit_ok       = flag_commit && (inflight_flags != '0);
    sf_written      = (queued_flags == '0) && (inflight_flags == '0);
    push_flags      = 2'd0;
    for (int i = 0; i < 3; i++) begin
      if (2'(i) < push_n && uop_sets_flags(wr_uop[i])) push_flags = push_flags + 2'd1;
    end
  end

  // Pointer, occupancy and FLAGS accounting.
  always_ff @(posedge clk) begin
    if (a_rst) begin
      head           <= '0;
      tail           <= '0;
      occupancy      <= '0;
      queued_flags   <= '0;
      inflight_flags <= '0;
    end else begin
      if (flush) begin
        head         <= '0;
        tail         <= '0;
        occupancy    <= '0;
        queued_flags <= '0;
      end else begin
        head         <= head + PTR_W'(pop);
        tail         <= tail + PTR_W'(push_n);
        occupancy    <= occupancy + OCC_W'(push_n) - OCC_W'(pop);
        queued_flags <= queued_flags + OCC_W'(push_flags) - OCC_W'(pop_flags);
      end
      // pop is forced low during flush, so only commits move this then.
      inflight_flags <= inflight_flags + IF_W'(pop_flags) - IF_W'(commit_ok);
    end
  end

  a_no_spurious_commit : assert property (@(posedge clk) disable iff (a_rst)
    !(flag_commit && (inflight_flags == '0)))
    else $error("flag_commit with no FLAGS uop in flight");

endmodule

// File: tb/tb_uop_issue_queue.sv
module tb_uop_issue_queue;
  import cpu_uop_pkg::*;

  logic       clk = 1'b0;
  logic       a_rst;
  logic       commit_a, flush_a, sf_a;
  logic       commit_b, flush_b, sf_b;
  logic [3:0] occ_a, occ_b;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  uop_issue_queue_if ifa();
  uop_issue_queue_if ifb();

  uop_issue_queue #(.DEPTH(8), .MAX_INFLIGHT(4)) dut_a (
    .clk(clk), .a_rst(a_rst), .bus(ifa), .flag_commit(commit_a),
    .flush(flush_a), .sf_written(sf_a), .occupancy(occ_a)
  );

  uop_issue_queue #(.DEPTH(8), .MAX_INFLIGHT(1)) dut_b (
    .clk(clk), .a_rst(a_rst), .bus(ifb), .flag_commit(commit_b),
    .flush(flush_b), .sf_written(sf_b), .occupancy(occ_b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    ifa.feed_ack = 1'b0; ifa.issue_ready = 1'b0; ifa.uop_count = 2'd0;
    ifa.uop_0 = '0; ifa.uop_1 = '0; ifa.uop_2 = '0;
    commit_a = 1'b0; flush_a = 1'b0;
    ifb.feed_ack = 1'b0; ifb.issue_ready = 1'b0; ifb.uop_count = 2'd0;
    ifb.uop_0 = '0; ifb.uop_1 = '0; ifb.uop_2 = '0;
    commit_b = 1'b0; flush_b = 1'b0;
  endtask

  task automatic push_a(input logic [19:0] u0, input logic [19:0] u1,
                        input logic [19:0] u2, input logic [1:0] cnt);
    ifa.uop_0 = uop_t'(u0); ifa.uop_1 = uop_t'(u1); ifa.uop_2 = uop_t'(u2);
    ifa.uop_count = cnt; ifa.feed_ack = 1'b1;
    tick();
    ifa.feed_ack = 1'b0; ifa.uop_count = 2'd0;
  endtask

  task automatic push_b(input logic [19:0] u0, input logic [19:0] u1,
                        input logic [1:0] cnt);
    ifb.uop_0 = uop_t'(u0); ifb.uop_1 = uop_t'(u1); ifb.uop_2 = '0;
    ifb.uop_count = cnt; ifb.feed_ack = 1'b1;
    tick();
    ifb.feed_ack = 1'b0; ifb.uop_count = 2'd0;
  endtask

  task automatic test_reset();
    idle_all();
    a_rst = 1'b1;
    flush_a = 1'b1;
    tick(); tick();
    a_rst = 1'b0; flush_a = 1'b0;
    #1;
    total_cnt++; if (ifa.feed_req !== 1'b1) $display("FAIL reset_feed_req got %b exp 1", ifa.feed_req); else pass_cnt++;
    total_cnt++; if (ifa.issue_valid !== 1'b0) $display("FAIL reset_issue_valid got %b exp 0", ifa.issue_valid); else pass_cnt++;
    total_cnt++; if (sf_a !== 1'b1) $display("FAIL reset_sf_written got %b exp 1", sf_a); else pass_cnt++;
    total_cnt++; if (occ_a !== 4'd0) $display("FAIL reset_occupancy got %0d exp 0", occ_a); else pass_cnt++;
    total_cnt++; if (ifa.issue_uop !== uop_t'(20'h0)) $display("FAIL reset_issue_uop got %h exp 0", ifa.issue_uop); else pass_cnt++;
    total_cnt++; if (ifb.feed_req !== 1'b1 || sf_b !== 1'b1) $display("FAIL reset_b got feed_req=%b sf=%b exp 1/1", ifb.feed_req, sf_b); else pass_cnt++;
  endtask

  task automatic test_fill();
    push_a(20'h00aaa, 20'h00bbb, 20'h00ccc, 2'd0);
    total_cnt++; if (occ_a !== 4'd0) $display("FAIL empty_bundle_occ got %0d exp 0", occ_a); else pass_cnt++;
    push_a(20'h00011, 20'h00012, 20'h00013, 2'd3);
    total_cnt++; if (occ_a !== 4'd3 || ifa.feed_req !== 1'b1) $display("FAIL fill_1 got occ=%0d req=%b exp 3/1", occ_a, ifa.feed_req); else pass_cnt++;
    push_a(20'h00014, 20'h00015, 20'h00016, 2'd3);
    total_cnt++; if (occ_a !== 4'd6 || ifa.feed_req !== 1'b0) $display("FAIL fill_2 got occ=%0d req=%b exp 6/0", occ_a, ifa.feed_req); else pass_cnt++;
    push_a(20'h00017, 20'h00018, 20'h00019, 2'd3);
    total_cnt++; if (occ_a !== 4'd6) $display("FAIL fill_ignored got occ=%0d exp 6", occ_a); else pass_cnt++;
    flush_a = 1'b1;
    #1;
    total_cnt++; if (ifa.feed_req !== 1'b0 || ifa.issue_valid !== 1'b0) $display("FAIL flush_gate got req=%b valid=%b exp 0/0", ifa.feed_req, ifa.issue_valid); else pass_cnt++;
    tick();
    flush_a = 1'b0;
    #1;
    total_cnt++; if (occ_a !== 4'd0 || ifa.feed_req !== 1'b1) $display("FAIL flush_empty got occ=%0d req=%b exp 0/1", occ_a, ifa.feed_req); else pass_cnt++;
  endtask

  task automatic test_drain_wrap();
    logic [19:0] exp_uop;
    exp_uop = 20'h00001;
    push_a(20'h00001, 20'h00002, 20'h00003, 2'd3);
    total_cnt++; if (ifa.issue_valid !== 1'b1 || ifa.issue_uop !== uop_t'(20'h00001)) $display("FAIL zero_latency got valid=%b uop=%h exp 1/00001", ifa.issue_valid, ifa.issue_uop); else pass_cnt++;
    push_a(20'h00004, 20'h00005, 20'h00006, 2'd3);
    ifa.issue_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      total_cnt++;
      if (ifa.issue_valid !== 1'b1 || ifa.issue_uop !== uop_t'(exp_uop)) $display("FAIL drain_order got valid=%b uop=%h exp 1/%h", ifa.issue_valid, ifa.issue_uop, exp_uop);
      else pass_cnt++;
      exp_uop = exp_uop + 20'd1;
      tick();
    end
    ifa.issue_ready = 1'b0;
    push_a(20'h00007, 20'h00008, 20'h00009, 2'd3);
    ifa.issue_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (ifa.issue_valid !== 1'b1 || ifa.issue_uop !== uop_t'(exp_uop)) $display("FAIL wrap_order got valid=%b uop=%h exp 1/%h", ifa.issue_valid, ifa.issue_uop, exp_uop);
      else pass_cnt++;
      exp_uop = exp_uop + 20'd1;
      tick();
    end
    ifa.issue_ready = 1'b0;
    total_cnt++; if (occ_a !== 4'd0 || ifa.issue_valid !== 1'b0) $display("FAIL drained got occ=%0d valid=%b exp 0/0", occ_a, ifa.issue_valid); else pass_cnt++;
  endtask

  task automatic test_flags();
    push_a(20'h01000, 20'h00000, 20'h01000, 2'd3);
    total_cnt++; if (sf_a !== 1'b0 || dut_a.queued_flags !== 4'd2) $display("FAIL flags_queued got sf=%b q=%0d exp 0/2", sf_a, dut_a.queued_flags); else pass_cnt++;
    ifa.issue_ready = 1'b1;
    tick(); tick(); tick();
    ifa.issue_ready = 1'b0;
    total_cnt++; if (occ_a !== 4'd0 || dut_a.inflight_flags !== 3'd2 || sf_a !== 1'b0) $display("FAIL flags_inflight got occ=%0d inf=%0d sf=%b exp 0/2/0", occ_a, dut_a.inflight_flags, sf_a); else pass_cnt++;
    commit_a = 1'b1;
    tick();
    total_cnt++; if (sf_a !== 1'b0) $display("FAIL flags_commit1 got sf=%b exp 0", sf_a); else pass_cnt++;
    tick();
    commit_a = 1'b0;
    total_cnt++; if (sf_a !== 1'b1) $display("FAIL flags_commit2 got sf=%b exp 1", sf_a); else pass_cnt++;
  endtask

  task automatic test_max_inflight();
    push_b(20'h01000, 20'h01001, 2'd2);
    total_cnt++; if (ifb.issue_valid !== 1'b1 || ifb.issue_uop !== uop_t'(20'h01000)) $display("FAIL maxinf_first got valid=%b uop=%h exp 1/01000", ifb.issue_valid, ifb.issue_uop); else pass_cnt++;
    ifb.issue_ready = 1'b1;
    tick();
    total_cnt++; if (ifb.issue_valid !== 1'b0 || occ_b !== 4'd1) $display("FAIL maxinf_stall got valid=%b occ=%0d exp 0/1", ifb.issue_valid, occ_b); else pass_cnt++;
    tick();
    total_cnt++; if (ifb.issue_valid !== 1'b0 || occ_b !== 4'd1) $display("FAIL maxinf_hold got valid=%b occ=%0d exp 0/1", ifb.issue_valid, occ_b); else pass_cnt++;
    ifb.issue_ready = 1'b0;
    commit_b = 1'b1;
    tick();
    commit_b = 1'b0;
    total_cnt++; if (ifb.issue_valid !== 1'b1 || ifb.issue_uop !== uop_t'(20'h01001)) $display("FAIL maxinf_release got valid=%b uop=%h exp 1/01001", ifb.issue_valid, ifb.issue_uop); else pass_cnt++;
    ifb.issue_ready = 1'b1;
    tick();
    ifb.issue_ready = 1'b0;
    commit_b = 1'b1;
    tick();
    commit_b = 1'b0;
    total_cnt++; if (occ_b !== 4'd0 || sf_b !== 1'b1) $display("FAIL maxinf_done got occ=%0d sf=%b exp 0/1", occ_b, sf_b); else pass_cnt++;
  endtask

  task automatic test_flush_collide();
    push_a(20'h01000, 20'h00010, 20'h00011, 2'd3);
    ifa.issue_ready = 1'b1;
    tick();
    ifa.issue_ready = 1'b0;
    push_a(20'h00020, 20'h01021, 20'h00022, 2'd3);
    total_cnt++; if (occ_a !== 4'd5 || sf_a !== 1'b0) $display("FAIL pre_flush got occ=%0d sf=%b exp 5/0", occ_a, sf_a); else pass_cnt++;
    flush_a = 1'b1;
    ifa.issue_ready = 1'b1;
    ifa.uop_0 = uop_t'(20'h01030); ifa.uop_1 = uop_t'(20'h01031); ifa.uop_2 = uop_t'(20'h01032);
    ifa.uop_count = 2'd3; ifa.feed_ack = 1'b1;
    #1;
    total_cnt++; if (ifa.feed_req !== 1'b0 || ifa.issue_valid !== 1'b0) $display("FAIL flush_collide_gate got req=%b valid=%b exp 0/0", ifa.feed_req, ifa.issue_valid); else pass_cnt++;
    tick();
    idle_all();
    #1;
    total_cnt++; if (occ_a !== 4'd0 || dut_a.queued_flags !== 4'd0) $display("FAIL flush_collide_occ got occ=%0d q=%0d exp 0/0", occ_a, dut_a.queued_flags); else pass_cnt++;
    total_cnt++; if (dut_a.inflight_flags !== 3'd1 || sf_a !== 1'b0) $display("FAIL flush_collide_inflight got inf=%0d sf=%b exp 1/0", dut_a.inflight_flags, sf_a); else pass_cnt++;
    commit_a = 1'b1;
    tick();
    commit_a = 1'b0;
    total_cnt++; if (sf_a !== 1'b1 || ifa.issue_valid !== 1'b0) $display("FAIL flush_commit got sf=%b valid=%b exp 1/0", sf_a, ifa.issue_valid); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain_wrap();
    test_flags();
    test_max_inflight();
    test_flush_collide();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached got running exp finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uop_issue_queue.md
Name: uop_issue_queue

Overview:
- Sits between decode_unit and the execute stage.
- Drives decode_unit's feed_req and accepts 0–3 uops per bundle on feed_ack.
- Buffers uops in a circular FIFO and issues one uop per cycle over a valid/ready handshake.
- Tracks outstanding flag-writing uops and generates sf_written for the decoder's branch resolution.

Parameters:
DEPTH, 8, FIFO entries; power of two, minimum 4
MAX_INFLIGHT, 4, max issued-but-uncommitted FLAGS uops; 1..7

Ports:
clk  in  1  system clock, all state on rising edge
a_rst  in  1  synchronous, active-high reset
feed_req  out  1  request a bundle from decode_unit
feed_ack  in  1  decode_unit presents a valid bundle this cycle
uop_0  in  20  first uop of bundle
uop_1  in  20  second uop
uop_2  in  20  third uop
uop_count  in  2  number of valid uops in bundle, 0..3
issue_valid  out  1  issue_uop is valid
issue_ready  in  1  execute stage accepts issue_uop
issue_uop  out  20  head-of-queue uop
flag_commit  in  1  execute stage has written SF for one FLAGS uop
flush  in  1  branch taken / pc invalidated; discard queued uops
sf_written  out  1  no FLAGS uop queued or in flight
occupancy  out  $clog2(DEPTH)+1  current entry count (debug/perf)

Behaviour:
- Uop field map: ALU[19:16], MASK[15], LD[14], WR[13], FLAGS[12], DEST[11:8], ALU_MUX[7:6], B[5:3], A[2:0]. Only FLAGS is interpreted; all other bits are stored verbatim.
- Reset (a_rst high at a rising edge): head=tail=0, occupancy=0, queued_flags=0, inflight_flags=0.
  - Outputs after reset: feed_req=1, issue_valid=0, issue_uop=0 (entry 0 is cleared at reset), sf_written=1.
  - a_rst overrides flush, feed_ack, issue_ready and flag_commit in the same cycle.
- feed_req: combinational from registers = !flush && (DEPTH - occupancy >= 3).
- Enqueue:
  - Occurs on a rising edge with feed_req && feed_ack.
  - Writes uop_0..uop_{n-1} to tail, tail+1, tail+2 (mod DEPTH); n = uop_count.
  - tail += n. uop_count=0 is a legal empty bundle: no state change.
  - feed_ack while feed_req=0 is ignored; decode_unit must hold the bundle.
- Issue:
  - issue_uop = mem[head].
  - issue_valid = (occupancy != 0) && !flush && !(mem[head].FLAGS && inflight_flags == MAX_INFLIGHT).
  - On issue_valid && issue_ready: head += 1 (mod DEPTH).
  - If the popped uop has FLAGS=1: queued_flags -= 1 and inflight_flags += 1.
  - Zero-latency path: a uop enqueued at edge k can issue in cycle k+1.
- Simultaneous push and pop:
  - occupancy_next = occupancy + n - pop.
  - Overflow is impossible, because feed_req is gated on current free >= 3.
  - Underflow is impossible, because pop requires occupancy != 0.
- Flag accounting:
  - queued_flags += popcount(FLAGS of enqueued uops), 0..3, minus 1 if a FLAGS uop is popped that cycle.
  - inflight_flags += 1 on a FLAGS pop, -= 1 on flag_commit; simultaneous inc and dec leaves it unchanged.
  - flag_commit with inflight_flags=0 is ignored; simulation assertion error.
  - sf_written = (queued_flags == 0) && (inflight_flags == 0), registered-state derived, combinational output.
- Flush (synchronous, single- or multi-cycle):
  - head=tail=0, occupancy=0, queued_flags=0.
  - inflight_flags is unchanged: issued uops still commit.
  - While flush is high, feed_req=0 and issue_valid=0, so a same-cycle feed_ack or issue_ready has no effect.
- Wrap-around: pointers are PTR_W=$clog2(DEPTH) bits with natural modulo wrap; a bundle may straddle the DEPTH-1 → 0 boundary.

Decomposition:
- Shared package cpu_uop_pkg:
  - UOP_W=20 and field bit positions (UOP_FLAGS_BIT=12, etc.).
  - uop_t typedef.
  - Function uop_sets_flags().
  - This package is also consumed by decode_unit and execute.
- One natural sub-module: uop_fifo_mem. It holds the DEPTH×20 storage with 3 write ports at consecutive addresses and one async read port. Pointer, occupancy and flag logic stay in the top level.

Test Plan:
- Reset then idle: a_rst=1 for 2 cycles → feed_req=1, issue_valid=0, sf_written=1, occupancy=0.
- Fill: issue_ready=0; 3 bundles of count=3 with FLAGS=0 → occupancy 3, 6. feed_req drops to 0 at occupancy 6 (free=2); a 4th feed_ack is ignored and occupancy stays 6.
- Drain order and wrap: enqueue bundles 0x00001..0x00003 and 0x00004..0x00006; pop 6; enqueue 0x00007..0x00009 (straddles index 7→0) → issue_uop sequence is exactly 0x00001..0x00009, one per cycle with issue_ready=1.
- Flag tracking: enqueue [0x01000, 0x00000, 0x01000] (two FLAGS) → sf_written=0, queued_flags=2. Issue all → inflight=2. flag_commit twice → sf_written=1 in the cycle after the second commit.
- MAX_INFLIGHT stall: MAX_INFLIGHT=1; queue two FLAGS uops; issue first; no commit → issue_valid=0 with head FLAGS. Pulse flag_commit → issue_valid=1 next cycle.
- Flush with simultaneous events: occupancy=5 with one FLAGS uop queued and one in flight; assert flush together with feed_ack (count=3) and issue_ready → next cycle occupancy=0, queued_flags=0, inflight_flags=1, sf_written=0, no uop issued or enqueued.
